// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access; one fixed-latency access at a time.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            own_dm;
    logic            own_we;
    logic            if_forced;
    logic            dm_win;
    logic            if_win;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    logic [SW-1:0] starve;
    assign if_forced = if_req && (starve == SW'(STARVE_MAX));
`else
    assign if_forced = 1'b0;
`endif

    // Grants are gated by reset so nothing is accepted while rst is held low.
    assign dm_win = rst && (state == IDLE) && dm_req && !if_forced;
    assign if_win = rst && (state == IDLE) && if_req && !dm_win;
    assign dm_gnt = dm_win;
    assign if_gnt = if_win;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            own_dm    <= 1'b0;
            own_we    <= 1'b0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (if_win || dm_win) begin
                        // The command registers double as the latched request copy.
                        own_dm    <= dm_win;
                        own_we    <= dm_win && dm_we;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_win && dm_we;
                        mem_addr  <= dm_win ? dm_addr : if_addr;
                        mem_wdata <= dm_win ? dm_wdata : '0;
                        state     <= ISSUE;
`ifdef ARB_STARVE_GUARD_EN
                        if (dm_win && if_req)
                            starve <= (starve == SW'(STARVE_MAX)) ? starve : starve + 1'b1;
                        else
                            starve <= '0;
`endif
                    end
                end
                ISSUE: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    cnt       <= CW'(MEM_LAT - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (own_dm) begin
                            dm_ack <= 1'b1;
                            if (!own_we)
                                dm_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle-offset reference model plus directed and random steps.
// Follows ARB_STARVE_GUARD_EN when the design is built with it.
module tb_mem_port_arbiter;

    localparam int ML = 2;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(ML), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    function automatic bit [31:0] bg(bit [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234};
    endfunction

    // Memory environment: fixed latency, garbage outside the valid cycle.
    bit [31:0] env_mem [bit [31:0]];
    int        rd_due = -1;
    bit [31:0] rd_val;
    always @(negedge clk) begin
        mem_rdata = (cyc == rd_due) ? rd_val : $urandom;
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) env_mem[mem_addr] = mem_wdata;
            rd_val = env_mem.exists(mem_addr) ? env_mem[mem_addr] : bg(mem_addr);
            rd_due = cyc + ML;
        end
    end

    // Reference model state: transaction granted at cycle t0 runs for ML+3 cycles.
    bit        act = 0;
    int        t0;
    bit        o_dm, o_we;
    bit [31:0] o_addr, o_wd, o_rd;
    bit [31:0] e_ifr = 0, e_dmr = 0;
    int        starve = 0;
    bit [31:0] ref_mem [bit [31:0]];
    bit        g_if, g_dm;
    bit        auto_drop = 1;
    bit        obs_if, obs_dm;
    int        obs_cyc, n_if_g, n_dm_g;
    int        n_tests = 0, n_fail = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_cycle();
        bit e_men, e_mwe, e_ifa, e_dma, e_busy, idle, force_if;
        bit [31:0] e_madr, e_mwd;
        int d;
        e_men = 0; e_mwe = 0; e_ifa = 0; e_dma = 0; e_busy = 0;
        e_madr = 0; e_mwd = 0; g_if = 0; g_dm = 0;
        if (rst !== 1'b1) begin
            act = 0; e_ifr = 0; e_dmr = 0; starve = 0;
        end else begin
            d = act ? cyc - t0 : 0;
            e_busy = act && d >= 1 && d <= ML + 2;
            if (act && d == 1) begin
                e_men = 1; e_mwe = o_we; e_madr = o_addr; e_mwd = o_wd;
            end
            if (act && d == ML + 2) begin
                if (o_dm) begin
                    e_dma = 1;
                    if (!o_we) e_dmr = o_rd;
                end else begin
                    e_ifa = 1; e_ifr = o_rd;
                end
            end
            idle = !act || d >= ML + 3;
            if (idle) begin
                act = 0;
`ifdef ARB_STARVE_GUARD_EN
                force_if = if_req && starve == SM;
`else
                force_if = 0;
`endif
                if (dm_req && !force_if) g_dm = 1;
                else if (if_req) g_if = 1;
                if (g_dm || g_if) begin
                    act = 1; t0 = cyc; o_dm = g_dm;
                    o_we = g_dm && dm_we;
                    o_addr = g_dm ? dm_addr : if_addr;
                    o_wd = g_dm ? dm_wdata : 32'h0;
                    if (o_we) ref_mem[o_addr] = o_wd;
                    o_rd = ref_mem.exists(o_addr) ? ref_mem[o_addr] : bg(o_addr);
                    if (g_dm && if_req) starve = (starve < SM) ? starve + 1 : SM;
                    else starve = 0;
                end
            end
        end
        chk("if_gnt", if_gnt, g_if);
        chk("dm_gnt", dm_gnt, g_dm);
        chk("if_ack", if_ack, e_ifa);
        chk("dm_ack", dm_ack, e_dma);
        chk("if_rdata", if_rdata, e_ifr);
        chk("dm_rdata", dm_rdata, e_dmr);
        chk("mem_en", mem_en, e_men);
        chk("mem_we", mem_we, e_mwe);
        chk("mem_addr", mem_addr, e_madr);
        chk("mem_wdata", mem_wdata, e_mwd);
        chk("busy", busy, e_busy);
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        obs_if = (if_gnt === 1'b1);
        obs_dm = (dm_gnt === 1'b1);
        obs_cyc = cyc;
        if (obs_if) n_if_g++;
        if (obs_dm) n_dm_g++;
        @(posedge clk);
        #1;
        if (auto_drop) begin
            if (g_if) begin if_req = 0; if_addr = $urandom; end
            if (g_dm) begin dm_req = 0; dm_addr = $urandom; dm_wdata = $urandom; dm_we = $urandom_range(1); end
        end
    endtask

    task automatic preload(bit [31:0] a, bit [31:0] v);
        env_mem[a] = v;
        ref_mem[a] = v;
    endtask

    initial begin
        int prev;
        rst = 0; if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 0;
        dm_addr = 32'h300; dm_wdata = 32'h0;

        // Reset held with both requests present, then release.
        repeat (3) tick();
        rst = 1;
        repeat (12) tick();

        // Single fetch.
        preload(32'h40, 32'h8C220004);
        if_req = 1; if_addr = 32'h40;
        repeat (6) tick();
        chk("fetch_data", if_rdata, 32'h8C220004);

        // Store then load at 0x100.
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        repeat (6) tick();
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        repeat (6) tick();
        chk("load_after_store", dm_rdata, 32'hDEADBEEF);

        // Contention for ten transactions.
        auto_drop = 0; n_if_g = 0; n_dm_g = 0;
        if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        repeat (10 * (ML + 3)) tick();
        if_req = 0; dm_req = 0; auto_drop = 1;
`ifdef ARB_STARVE_GUARD_EN
        chk("contend_if_grants", n_if_g, 10 / (SM + 1));
        chk("contend_dm_grants", n_dm_g, 10 - 10 / (SM + 1));
`else
        chk("contend_if_grants", n_if_g, 0);
        chk("contend_dm_grants", n_dm_g, 10);
`endif
        repeat (6) tick();

        // Reset during WAIT of a load.
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        repeat (3) tick();
        rst = 0;
        repeat (2) tick();
        chk("rst_clears_dm_rdata", dm_rdata, 32'h0);
        rst = 1;
        repeat (4) tick();
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        repeat (6) tick();
        chk("load_after_reset", dm_rdata, 32'hDEADBEEF);

        // Back-to-back fetches with if_req held.
        auto_drop = 0; prev = -1;
        if_req = 1; if_addr = 32'h40;
        repeat (4 * (ML + 3)) begin
            tick();
            if (obs_if) begin
                if (prev >= 0) chk("b2b_gap", obs_cyc - prev, ML + 3);
                prev = obs_cyc;
            end
        end
        if_req = 0; auto_drop = 1;
        repeat (6) tick();

        // Randomized traffic with occasional reset pulses.
        repeat (600) begin
            rst = ($urandom_range(199) != 0);
            if (!if_req && $urandom_range(3) == 0) begin
                if_req = 1; if_addr = {26'h0, 4'($urandom_range(15)), 2'b00};
            end
            if (!dm_req && $urandom_range(3) == 0) begin
                dm_req = 1; dm_we = $urandom_range(1); dm_wdata = $urandom;
                dm_addr = {26'h0, 4'($urandom_range(15)), 2'b00};
            end
            tick();
        end
        rst = 1; if_req = 0; dm_req = 0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
